// File: rtl/jtag_host_shifter.sv
// JTAG initiator: generates TCK/TMS/TDI for TAP reset, IR scans and DR scans.
// It returns the TDO bits captured during the shift phase on data_out_o.
//
// state   | meaning
// IDLE    | waiting for start_i, TCK held low
// RST_SEQ | five TMS=1 periods, then one TMS=0 period (ends in Run-Test/Idle)
// HDR     | Run-Test/Idle to Shift-IR/DR walk (IR: 1,1,0,0  DR: 1,0,0)
// SHIFT   | N data periods, with TMS=1 on the last one (Exit1)
// TAIL    | Update (TMS=1), then Run-Test/Idle (TMS=0)
// FINISH  | one-cycle done_o pulse; a new command may be accepted here
module jtag_host_shifter #(
  parameter int DIV    = 2,
  parameter int MAXLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [1:0]        cmd_i,
  input  logic [4:0]        len_i,
  input  logic [MAXLEN-1:0] data_in_i,
  input  logic              tdo_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [MAXLEN-1:0] data_out_o,
  output logic              tck_o,
  output logic              tms_o,
  output logic              tdi_o
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = $clog2(MAXLEN);

  typedef enum logic [2:0] {
    IDLE, RST_SEQ, HDR, SHIFT, TAIL, FINISH
  } state_t;

  state_t            state_q, state_d, nxt_st;
  logic [DW-1:0]     div_q, div_d;
  logic              tck_q, tck_d;
  logic              tms_q, tms_d;
  logic              tdi_q, tdi_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [5:0]        len_q, len_d;
  logic              ir_q, ir_d;
  logic [MAXLEN-1:0] din_q, din_d;
  logic [MAXLEN-1:0] dout_q, dout_d;
  logic [5:0]        cnt_inc;

  function automatic logic tms_of(state_t st, logic [5:0] k, logic ir, logic [5:0] n);
    case (st)
      RST_SEQ: tms_of = (k != 6'd5);
      HDR:     tms_of = ir ? (k < 6'd2) : (k == 6'd0);
      SHIFT:   tms_of = (k == n - 6'd1);
      TAIL:    tms_of = (k == 6'd0);
      default: tms_of = 1'b0;
    endcase
  endfunction

  function automatic logic last_of(state_t st, logic [5:0] k, logic ir, logic [5:0] n);
    case (st)
      RST_SEQ: last_of = (k == 6'd5);
      HDR:     last_of = (k == (ir ? 6'd3 : 6'd2));
      SHIFT:   last_of = (k == n - 6'd1);
      TAIL:    last_of = (k == 6'd1);
      default: last_of = 1'b1;
    endcase
  endfunction

  function automatic state_t next_of(state_t st);
    case (st)
      HDR:     next_of = SHIFT;
      SHIFT:   next_of = TAIL;
      default: next_of = FINISH;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tck_d   = tck_q;
    tms_d   = tms_q;
    tdi_d   = tdi_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ir_d    = ir_q;
    din_d   = din_q;
    dout_d  = dout_q;
    nxt_st  = next_of(state_q);
    cnt_inc = cnt_q + 6'd1;

    case (state_q)
      IDLE, FINISH: begin
        if (state_q == FINISH) state_d = IDLE;
        if (start_i) begin
          ir_d    = (cmd_i == 2'b01);
          state_d = (cmd_i == 2'b01 || cmd_i == 2'b10) ? HDR : RST_SEQ;
          len_d   = (len_i == 5'd0) ? 6'd32 : {1'b0, len_i};
          din_d   = data_in_i;
          dout_d  = '0;
          cnt_d   = '0;
          div_d   = DW'(DIV - 1);
          tck_d   = 1'b0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
        end
      end
      default: begin
        if (div_q != '0) begin
          div_d = div_q - DW'(1);
        end else begin
          div_d = DW'(DIV - 1);
          if (!tck_q) begin
            tck_d = 1'b1;
            if (state_q == SHIFT) dout_d[cnt_q[IW-1:0]] = tdo_i;
          end else begin
            // Falling edge: the next period's TMS/TDI launch together with it.
            tck_d = 1'b0;
            if (!last_of(state_q, cnt_q, ir_q, len_q)) begin
              cnt_d = cnt_inc;
              tms_d = tms_of(state_q, cnt_inc, ir_q, len_q);
              tdi_d = (state_q == SHIFT) ? din_q[cnt_inc[IW-1:0]] : 1'b0;
            end else begin
              state_d = nxt_st;
              cnt_d   = '0;
              tms_d   = tms_of(nxt_st, 6'd0, ir_q, len_q);
              tdi_d   = (nxt_st == SHIFT) ? din_q[0] : 1'b0;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      div_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
      ir_q    <= 1'b0;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  assign busy_o     = (state_q != IDLE) && (state_q != FINISH);
  assign done_o     = (state_q == FINISH);
  assign data_out_o = dout_q;
  assign tck_o      = tck_q;
  assign tms_o      = tms_q;
  assign tdi_o      = tdi_q;

endmodule

// File: tb/tb_jtag_host_shifter.sv
// Directed bench for jtag_host_shifter: a vector table of whole commands plus
// hand-written sequences for busy-time START, START in the DONE cycle and mid-scan reset.
module tb_jtag_host_shifter;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n, start, tdo;
  logic [1:0]  cmd;
  logic [4:0]  len;
  logic [31:0] din;
  logic        busy, done, tck, tms, tdi;
  logic [31:0] dout;
  int          tdo_mode;
  logic        lb_q;
  bit          tms_hist[$];
  bit          tdi_hist[$];
  int          checks = 0;
  int          errors = 0;

  jtag_host_shifter #(.DIV(DIV), .MAXLEN(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cmd_i(cmd), .len_i(len),
    .data_in_i(din), .tdo_i(tdo), .busy_o(busy), .done_o(done),
    .data_out_o(dout), .tck_o(tck), .tms_o(tms), .tdi_o(tdi)
  );

  always #5 clk = ~clk;

  // TAP stand-ins: 0 tied low, 1 tied high, 2 TDI wired to TDO, 3 one-flop loopback on TCK rise
  always @(posedge tck) lb_q <= tdi;
  assign tdo = (tdo_mode == 0) ? 1'b0 : (tdo_mode == 1) ? 1'b1 :
               (tdo_mode == 2) ? tdi : lb_q;

  always @(posedge tck) begin
    tms_hist.push_back(tms);
    tdi_hist.push_back(tdi);
  end

  typedef struct {
    string       name;
    logic [1:0]  cmd;
    logic [4:0]  len;
    logic [31:0] din;
    int          mode;
    int          periods;
    logic [63:0] tms_pat;
    logic [63:0] tdi_pat;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input vec_t v);
    int cyc, base;
    logic [63:0] tms_act, tdi_act;
    base = tms_hist.size();
    cmd = v.cmd; len = v.len; din = v.din; tdo_mode = v.mode;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({v.name, " busy_after_accept"}, 64'(busy), 64'd1);
    chk({v.name, " dout_cleared"}, 64'(dout), 64'd0);
    wait_done(cyc);
    chk({v.name, " done_latency"}, 64'(cyc), 64'(2 * DIV * v.periods + 1));
    chk({v.name, " done_cycle_busy_tck_tms"}, {61'd0, busy, tck, tms}, 64'd0);
    chk({v.name, " tck_periods"}, 64'(tms_hist.size() - base), 64'(v.periods));
    tms_act = '0; tdi_act = '0;
    for (int p = 0; p < v.periods && p < 64 && base + p < tms_hist.size(); p++) begin
      tms_act[p] = tms_hist[base + p];
      tdi_act[p] = tdi_hist[base + p];
    end
    chk({v.name, " tms_seq"}, tms_act, v.tms_pat);
    chk({v.name, " tdi_seq"}, tdi_act, v.tdi_pat);
    chk({v.name, " data_out"}, 64'(dout), 64'(v.dout));
    @(posedge clk); #1;
    chk({v.name, " done_one_cycle"}, 64'(done), 64'd0);
    chk({v.name, " data_out_held"}, 64'(dout), 64'(v.dout));
  endtask

  initial begin
    int cyc, base, ndone, dcyc;
    logic [31:0] cap;

    vecs[0] = '{"rst00",   2'b00, 5'd0, 32'h0,        1, 6,  64'h1F,        64'h0,          32'h0};
    vecs[1] = '{"dr8_lb",  2'b10, 5'd8, 32'hA5,       3, 13, 64'hC01,       64'h528,        32'h4A};
    vecs[2] = '{"ir4",     2'b01, 5'd4, 32'h3,        1, 10, 64'h183,       64'h30,         32'hF};
    vecs[3] = '{"dr32",    2'b10, 5'd0, 32'hDEADBEEF, 2, 37, 64'hC_0000_0001, 64'h6_F56D_F778, 32'hDEADBEEF};
    vecs[4] = '{"rst11",   2'b11, 5'd9, 32'hFFFFFFFF, 1, 6,  64'h1F,        64'h0,          32'h0};
    vecs[5] = '{"ir1",     2'b01, 5'd1, 32'h1,        0, 7,  64'h33,        64'h10,         32'h0};
    vecs[6] = '{"dr5_lb",  2'b10, 5'd5, 32'hFFFFFFFF, 3, 10, 64'h181,       64'hF8,         32'h1E};

    rst_n = 1'b0; start = 1'b0; cmd = '0; len = '0; din = '0; tdo_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {58'd0, tck, tms, tdi, busy, done, 1'b0}, {58'd0, 6'b010000});
    chk("reset_dout", 64'(dout), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run(vecs[i]);

    // START held during a scan with changing operands: only the first accept counts
    base = tms_hist.size();
    cmd = 2'b10; len = 5'd8; din = 32'hA5; tdo_mode = 2;
    start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; dcyc = 0; cap = '0;
    for (int c = 1; c <= 120; c++) begin
      if (done) begin
        ndone++; dcyc = c; cap = dout;
      end
      start = (c < 40);
      cmd = 2'($urandom_range(3));
      len = 5'($urandom_range(31));
      din = $urandom;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_start done_count", 64'(ndone), 64'd1);
    chk("busy_start done_latency", 64'(dcyc), 64'd53);
    chk("busy_start data_out", 64'(cap), 64'hA5);
    chk("busy_start periods", 64'(tms_hist.size() - base), 64'd13);

    // START presented in the DONE cycle is accepted
    cmd = 2'b01; len = 5'd4; din = 32'h3; tdo_mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    chk("done_accept first_latency", 64'(cyc), 64'd41);
    cmd = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_accept busy", 64'(busy), 64'd1);
    chk("done_accept dout_cleared", 64'(dout), 64'd0);
    wait_done(cyc);
    chk("done_accept rst_latency", 64'(cyc), 64'd25);
    @(posedge clk); #1;

    // Reset in the middle of a shift aborts with no further TCK edges
    cmd = 2'b10; len = 5'd16; din = 32'hFFFF; tdo_mode = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midshift dout_partial", 64'(dout != 32'h0), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midshift_reset tck_tms_busy_done", {60'd0, tck, tms, busy, done}, 64'b0100);
    chk("midshift_reset dout", 64'(dout), 64'd0);
    rst_n = 1'b1;
    base = tms_hist.size();
    repeat (12) @(posedge clk);
    #1;
    chk("midshift_reset no_tck", 64'(tms_hist.size() - base), 64'd0);
    run(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
